// File: rtl/skid_reg32_if.sv
// Handshake bundle for the two-entry skid register: producer side (in_*),
// consumer side (out_*) and the occupancy count.
interface skid_reg32_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [1:0]       count;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready,
        input  count
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready,
        output count
    );
endinterface

// File: rtl/skid_reg32.sv
// Two-entry skid register: MAIN always drives out_data, SKID absorbs one word
// so in_ready can be decoded from state alone, with no path from out_ready.
module skid_reg32 #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         flush,
    skid_reg32_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;
    logic             in_ready_s;
    logic             out_valid_s;
    logic             push_s;
    logic             pop_s;

    // Handshake flags decoded purely from the state register
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
            end
            ST_ONE: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b1;
            end
            ST_TWO: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b1;
            end
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    assign push_s        = bus.in_valid & in_ready_s;
    assign pop_s         = out_valid_s & bus.out_ready;
    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_data  = main_q;
    assign bus.count     = state_q;

    // Next-state and storage update; flush overrides any handshake
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push_s) begin
                        main_d  = bus.in_data;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (push_s && pop_s) begin
                        main_d  = bus.in_data;
                        state_d = ST_ONE;
                    end else if (push_s) begin
                        skid_d  = bus.in_data;
                        state_d = ST_TWO;
                    end else if (pop_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (pop_s) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and storage registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q <= ST_EMPTY;
            main_q  <= {WIDTH{1'b0}};
            skid_q  <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end
endmodule

// File: tb/tb_skid_reg32.sv
// Bench for skid_reg32: directed scenarios with literal expectations, then
// random traffic checked every cycle against a queue-based reference model.
module tb_skid_reg32;
    logic clk;
    logic clr_n;
    logic flush;
    int   checks;
    int   errors;

    skid_reg32_if #(.WIDTH(32)) bus_if ();

    skid_reg32 #(.WIDTH(32)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .flush (flush),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the stage is a FIFO of depth two
    logic [31:0] q[$];
    logic [31:0] main_m;
    bit          main_known;
    bit          active;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit          push;
        bit          pop;
        logic [31:0] popped;
        if (!clr_n) begin
            q.delete();
            main_m     = 32'd0;
            main_known = 1'b1;
            active     = 1'b1;
        end else if (flush) begin
            q.delete();
            main_known = 1'b0;
        end else begin
            push = bus_if.in_valid && (q.size() < 2);
            pop  = (q.size() > 0) && bus_if.out_ready;
            if (pop) begin
                popped = q.pop_front();
                if (q.size() == 0 && !push) begin
                    main_m     = popped;
                    main_known = 1'b1;
                end
            end
            if (push) q.push_back(bus_if.in_data);
        end
    end

    always @(negedge clk) begin
        if (active) begin
            chk("m_out_valid", {31'd0, bus_if.out_valid}, {31'd0, q.size() != 0});
            chk("m_in_ready",  {31'd0, bus_if.in_ready},  {31'd0, q.size() != 2});
            chk("m_count",     {30'd0, bus_if.count},     q.size());
            if (q.size() > 0) chk("m_out_data", bus_if.out_data, q[0]);
            else if (main_known) chk("m_held_data", bus_if.out_data, main_m);
        end
    end

    // Apply one cycle of inputs and return at the following negedge
    task automatic cyc(input logic rn, input logic fl, input logic iv,
                       input logic [31:0] d, input logic ordy);
        clr_n            = rn;
        flush            = fl;
        bus_if.in_valid  = iv;
        bus_if.in_data   = d;
        bus_if.out_ready = ordy;
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        active = 1'b0;
        main_known = 1'b0;
        clr_n = 1'b0;
        flush = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = 32'd0;
        bus_if.out_ready = 1'b0;
        @(negedge clk);

        // Reset while a push is offered
        cyc(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        chk("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, bus_if.in_ready},  32'd1);
        chk("rst_count",     {30'd0, bus_if.count},     32'd0);
        chk("rst_out_data",  bus_if.out_data,           32'd0);

        // Streaming at full rate
        cyc(1'b1, 1'b0, 1'b1, 32'h1, 1'b1);
        chk("stream_d1", bus_if.out_data, 32'h1);
        chk("stream_c1", {30'd0, bus_if.count}, 32'd1);
        cyc(1'b1, 1'b0, 1'b1, 32'h2, 1'b1);
        chk("stream_d2", bus_if.out_data, 32'h2);
        chk("stream_r2", {31'd0, bus_if.in_ready}, 32'd1);
        cyc(1'b1, 1'b0, 1'b1, 32'h3, 1'b1);
        chk("stream_d3", bus_if.out_data, 32'h3);
        chk("stream_c3", {30'd0, bus_if.count}, 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("stream_drain", {30'd0, bus_if.count}, 32'd0);

        // Backpressure fills SKID, third word refused
        cyc(1'b1, 1'b0, 1'b1, 32'hA, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'hB, 1'b0);
        chk("bp_count2",  {30'd0, bus_if.count}, 32'd2);
        chk("bp_ready0",  {31'd0, bus_if.in_ready}, 32'd0);
        chk("bp_hold_a",  bus_if.out_data, 32'hA);
        cyc(1'b1, 1'b0, 1'b1, 32'hC, 1'b0);
        chk("bp_still_a", bus_if.out_data, 32'hA);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("bp_pop_b",   bus_if.out_data, 32'hB);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("bp_empty",   {30'd0, bus_if.count}, 32'd0);
        chk("bp_main_kept", bus_if.out_data, 32'hB);

        // Push and pop together in ONE
        cyc(1'b1, 1'b0, 1'b1, 32'h5, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'h6, 1'b1);
        chk("sim_data", bus_if.out_data, 32'h6);
        chk("sim_count", {30'd0, bus_if.count}, 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        // Flush in TWO discards both words and the concurrent handshake
        cyc(1'b1, 1'b0, 1'b1, 32'h11, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'h22, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'h33, 1'b1);
        chk("fl_count", {30'd0, bus_if.count}, 32'd0);
        chk("fl_valid", {31'd0, bus_if.out_valid}, 32'd0);
        chk("fl_ready", {31'd0, bus_if.in_ready}, 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("fl_no_word", {31'd0, bus_if.out_valid}, 32'd0);

        // Reset in TWO, then normal operation resumes
        cyc(1'b1, 1'b0, 1'b1, 32'h44, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'h55, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 32'h66, 1'b1);
        chk("rt_count", {30'd0, bus_if.count}, 32'd0);
        chk("rt_data",  bus_if.out_data, 32'd0);
        cyc(1'b1, 1'b0, 1'b1, 32'h7, 1'b0);
        chk("rt_valid", {31'd0, bus_if.out_valid}, 32'd1);
        chk("rt_push7", bus_if.out_data, 32'h7);

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) != 0),
                ($urandom_range(0, 49) == 0),
                ($urandom_range(0, 3) != 0),
                $urandom,
                ($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/skid_reg32.md
SKID_REG32 -- requirements
Module: skid_reg32

Interface
REQ-001 Parameter: WIDTH, default 32, data path width in bits.
REQ-002 The clocking and reset scheme SHALL be: one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 clr_n  input  1  synchronous active-low reset.
REQ-005 flush  input  1  synchronous discard of all buffered data; active-high.
REQ-006 in_valid  input  1  producer presents in_data this cycle.
REQ-007 in_data  input  WIDTH  producer data.
REQ-008 in_ready  output  1  stage can accept in_data this cycle.
REQ-009 out_valid  output  1  out_data holds a valid word.
REQ-010 out_data  output  WIDTH  oldest buffered word.
REQ-011 out_ready  input  1  consumer takes out_data this cycle.
REQ-012 count  output  2  words held: 0, 1 or 2.

Function
REQ-013 Push SHALL occur when in_valid & in_ready are both 1 at a rising edge; pop SHALL occur when out_valid & out_ready are both 1.
REQ-014 Storage SHALL be two WIDTH-bit registers: MAIN (drives out_data) and SKID.
REQ-015 State machine SHALL have three states: EMPTY (count 0), ONE (count 1), TWO (count 2).
REQ-016 in_ready SHALL be 1 in EMPTY and ONE and 0 in TWO, and SHALL be decoded from state only, with no combinational path from out_ready.
REQ-017 out_valid SHALL be 1 in ONE and TWO and 0 in EMPTY; out_data SHALL always equal MAIN.
REQ-018 EMPTY, push: MAIN <= in_data, go to ONE; no push: stay.
REQ-019 ONE, push and pop: MAIN <= in_data, stay ONE.
REQ-020 ONE, push only: SKID <= in_data, go to TWO.
REQ-021 ONE, pop only: go to EMPTY, MAIN unchanged.
REQ-022 TWO, pop: MAIN <= SKID, go to ONE; no pop: hold all state.
REQ-023 Latency SHALL be one cycle from push into EMPTY to out_valid=1; sustained throughput SHALL be one word per cycle while out_ready=1.
REQ-024 Ordering SHALL be strictly FIFO; no word SHALL be duplicated or dropped except by flush or reset.
REQ-025 While out_valid=1 and out_ready=0, out_data SHALL remain stable until popped.
REQ-026 MAIN and SKID SHALL be written only as listed in REQ-018 to REQ-022; in_data is ignored when no push occurs.
REQ-027 flush=1 SHALL force state to EMPTY at the next edge; a push or pop in the same cycle SHALL be discarded; MAIN/SKID contents are don't-care but out_data SHALL NOT be treated as valid.
REQ-028 count SHALL equal 0/1/2 for EMPTY/ONE/TWO.

Reset
REQ-029 clr_n=0 at a rising edge SHALL force state EMPTY, MAIN=0, SKID=0, hence out_valid=0, in_ready=1, out_data=0, count=0.
REQ-030 Reset SHALL take priority over flush and any handshake, including mid-transfer in state TWO.
REQ-031 Outputs SHALL change only on clock edges; no asynchronous path from clr_n.

Verification
REQ-032 Reset: clr_n=0 one cycle with in_valid=1, in_data=0xDEADBEEF -> after edge out_valid=0, in_ready=1, count=0, out_data=0.
REQ-033 Streaming: out_ready=1, push 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 on the following three cycles, count stays 1, in_ready stays 1.
REQ-034 Backpressure: out_ready=0, push 0xA then 0xB -> count=2, in_ready=0, out_data=0xA held; 0xC offered is not accepted; raise out_ready -> 0xA, 0xB popped in order, then count=0.
REQ-035 Simultaneous in ONE: MAIN=0x5, push 0x6 and pop same cycle -> next out_data=0x6, count=1.
REQ-036 Flush in TWO with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1; no word appears at output.
REQ-037 Reset mid-operation in TWO -> next cycle EMPTY, out_data=0; subsequent push 0x7 appears at output one cycle later.
